// File: rtl/timer_irq_source_if.sv
// rtl/timer_irq_source_if.sv - register bus between the system bridge and the timer
interface timer_irq_source_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/timer_irq_source.sv
// rtl/timer_irq_source.sv - programmable countdown timer driving the core's external irq
// Optional feature macro: IRQ_STRETCH_EN (irq becomes a self-clearing IRQ_HOLD-cycle pulse).
module timer_irq_source #(
  parameter int CNT_W    = 32,
  parameter int IRQ_HOLD = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  timer_irq_source_if.slave bus,
  output logic              irq
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

  state_t           state_q, state_d;
  logic [3:0]       ctrl_q;
  logic [CNT_W-1:0] preset_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ctrl_wr, preset_wr;
  logic             en, im, auto_reload;
  logic             en_clr, irq_set;

  assign ctrl_wr     = bus.we && (bus.addr == 2'd0);
  assign preset_wr   = bus.we && (bus.addr == 2'd1);
  assign en          = ctrl_q[0];
  assign im          = ctrl_q[3];
  // Only MODE=01 reloads; 10 and 11 fall back to one-shot.
  assign auto_reload = (ctrl_q[2:1] == 2'b01);

  // Next-state, next-count and side effects of the countdown FSM
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    en_clr  = 1'b0;
    irq_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        // Decrement is gated by a nonzero count, so COUNT never wraps.
        if (!en)                  state_d = S_IDLE;
        else if (count_q == '0)   state_d = S_INT;
        else                      count_d = count_q - CNT_W'(1);
      end
      S_INT: begin
        irq_set = im;
        if (auto_reload) begin
          state_d = S_LOAD;
        end else begin
          en_clr  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and running count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // CTRL register; a software write beats the one-shot EN clear on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ctrl_q    <= '0;
    else if (ctrl_wr) ctrl_q    <= bus.wdata[3:0];
    else if (en_clr)  ctrl_q[0] <= 1'b0;
  end

  // PRESET register; a running count only sees a new value at the next LOAD
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       preset_q <= '0;
    else if (preset_wr) preset_q <= bus.wdata[CNT_W-1:0];
  end

`ifdef IRQ_STRETCH_EN
  localparam int HOLD_W = (IRQ_HOLD > 1) ? $clog2(IRQ_HOLD) : 1;
  logic [HOLD_W-1:0] hold_q;

  // Fixed-width pulse; a fresh expiry restarts the hold, CTRL writes do not cut it short
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq    <= 1'b0;
      hold_q <= '0;
    end else if (irq_set) begin
      irq    <= 1'b1;
      hold_q <= HOLD_W'(IRQ_HOLD - 1);
    end else if (hold_q != '0) begin
      hold_q <= hold_q - HOLD_W'(1);
    end else begin
      irq    <= 1'b0;
    end
  end
`else
  logic hold_unused;
  assign hold_unused = (IRQ_HOLD > 0);

  // Level irq: set on expiry with IM, acknowledged by any CTRL write; set wins a tie
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     irq <= 1'b0;
    else if (irq_set) irq <= 1'b1;
    else if (ctrl_wr) irq <= 1'b0;
  end
`endif

  // Combinational register read mux; unused upper CTRL bits and addr 3 read as zero
  always_comb begin
    bus.rdata = '0;
    case (bus.addr)
      2'd0:    bus.rdata = {28'd0, ctrl_q};
      2'd1:    bus.rdata = 32'(preset_q);
      2'd2:    bus.rdata = 32'(count_q);
      default: bus.rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_irq_source.sv
// tb/tb_timer_irq_source.sv - self-checking bench for timer_irq_source
module tb_timer_irq_source;

  logic clk;
  logic reset_n;
  logic irq;
  int   total;
  int   bad;

  timer_irq_source_if bus ();

  timer_irq_source #(.CNT_W(32), .IRQ_HOLD(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input logic [31:0] act,
                           input logic [31:0] lo, input logic [31:0] hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    @(posedge clk);
    #1;
    bus.we    = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_irq(input int maxc, output int k);
    k = -1;
    for (int i = 1; i <= maxc; i++) begin
      tick();
      if (irq) begin
        k = i;
        break;
      end
    end
  endtask

  // Timeline of a clean start: the enabling write is edge 0, k counts edges after it.
  function automatic void model(input int p, input int mode, input bit im, input int k,
                                output logic [31:0] cnt, output bit irq_e,
                                output logic [31:0] ctrl);
    bit auto_m;
    int ph;
    auto_m = (mode == 1);
    if (k < 2) begin
      cnt = 0;
    end else begin
      ph = k - 2;
      if (auto_m) ph = ph % (p + 3);
      cnt = (ph >= p) ? 0 : p - ph;
    end
    irq_e = im && (k >= 4 + p);
    ctrl  = {28'd0, im, 2'(mode), 1'b1};
    if (!auto_m && k >= 4 + p) ctrl[0] = 1'b0;
  endfunction

  initial begin
    logic [31:0] d, c, cexp, ctexp;
    bit          iexp;
    int          k, k2, p, mode, n;
    bit          im, found;

    total     = 0;
    bad       = 0;
    reset_n   = 1'b0;
    bus.addr  = 2'd0;
    bus.we    = 1'b0;
    bus.wdata = '0;

    vecs[0] = '{"preset_rw",  1'b1, 2'd1, 32'h1234_5678, 2'd1, 32'h1234_5678};
    vecs[1] = '{"ctrl_mask",  1'b1, 2'd0, 32'hFFFF_FFF6, 2'd0, 32'h0000_0006};
    vecs[2] = '{"ctrl_zero",  1'b1, 2'd0, 32'h0000_0000, 2'd0, 32'h0000_0000};
    vecs[3] = '{"count_ro",   1'b1, 2'd2, 32'h0000_00AA, 2'd2, 32'h0000_0000};
    vecs[4] = '{"addr3_rd",   1'b1, 2'd3, 32'hFFFF_FFFF, 2'd3, 32'h0000_0000};
    vecs[5] = '{"preset_rw2", 1'b1, 2'd1, 32'hDEAD_BEEF, 2'd1, 32'hDEAD_BEEF};
    vecs[6] = '{"we_low",     1'b0, 2'd1, 32'h0000_0005, 2'd1, 32'hDEAD_BEEF};
    vecs[7] = '{"ctrl_im",    1'b1, 2'd0, 32'h0000_0008, 2'd0, 32'h0000_0008};

    // Reset values while reset_n is held low
    #1;
    check("rst_irq", {31'd0, irq}, 32'd0);
    rd(2'd0, d); check("rst_ctrl", d, 32'd0);
    rd(2'd1, d); check("rst_preset", d, 32'd0);
    rd(2'd2, d); check("rst_count", d, 32'd0);
    reset_n = 1'b1;
    tick();

    // Register access table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].we) wr(vecs[i].waddr, vecs[i].wdata);
      else            tick();
      rd(vecs[i].raddr, d);
      check(vecs[i].name, d, vecs[i].exp);
    end

    // One-shot PRESET=5: irq after E9, EN self-clears
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    wait_irq(30, k);
    check("oneshot_lat", k, 32'd9);
    rd(2'd0, d); check("oneshot_ctrl", d, 32'h8);
    rd(2'd2, d); check("oneshot_count", d, 32'd0);

`ifndef IRQ_STRETCH_EN
    // Auto-reload PRESET=2: irq after E6, ack, next set 5 cycles after the first
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    wait_irq(30, k);
    check("auto_lat", k, 32'd6);
    wr(2'd0, 32'hB);
    check("auto_ack", {31'd0, irq}, 32'd0);
    wait_irq(30, k2);
    check("auto_period", k2, 32'd4);
`endif

    // Stop mid-count then re-enable
    do_reset();
    wr(2'd1, 32'd15);
    wr(2'd0, 32'h9);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      rd(2'd2, d);
      if (d == 32'd10) found = 1'b1;
    end
    check("stop_reach10", {31'd0, found}, 32'd1);
    wr(2'd0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick();
      rd(2'd2, d);
      check_rng("stop_count", d, 32'd9, 32'd10);
      check("stop_irq", {31'd0, irq}, 32'd0);
    end
    wr(2'd0, 32'h9);
    tick();
    tick();
    rd(2'd2, d);
    check("reenable_load", d, 32'd15);

    // PRESET=0 expiry, COUNT read-only, addr 3 reads zero
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    wait_irq(30, k);
    check("p0_lat", k, 32'd4);
    wr(2'd2, 32'h77);
    rd(2'd2, d); check("p0_count_ro", d, 32'd0);
    check("p0_irq_kept", {31'd0, irq}, 32'd1);
    rd(2'd3, d); check("p0_addr3", d, 32'd0);

    // Asynchronous reset mid-count with irq pending
    do_reset();
    wr(2'd1, 32'd6);
    wr(2'd0, 32'hB);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      rd(2'd2, d);
      if (irq && d == 32'd3) found = 1'b1;
    end
    check("arst_setup", {31'd0, found}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_irq", {31'd0, irq}, 32'd0);
    rd(2'd2, d); check("arst_count", d, 32'd0);
    rd(2'd0, d); check("arst_ctrl", d, 32'd0);
    reset_n = 1'b1;

`ifdef IRQ_STRETCH_EN
    // Pulse of exactly 5 cycles, not shortened by a CTRL write
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    wait_irq(30, k);
    check("pulse_lat", k, 32'd7);
    wr(2'd0, 32'h8);
    check("pulse_after_wr", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pulse_shape", {31'd0, irq}, (i < 3) ? 32'd1 : 32'd0);
    end
`endif

    // Randomized clean-start episodes against the timeline model
    for (int e = 0; e < 30; e++) begin
      do_reset();
      p    = $urandom_range(0, 12);
      mode = $urandom_range(0, 3);
      im   = 1'($urandom_range(0, 1));
      n    = $urandom_range(5, 45);
      wr(2'd1, 32'(p));
      wr(2'd0, {28'd0, im, 2'(mode), 1'b1});
      for (int kk = 1; kk <= n; kk++) begin
        tick();
        model(p, mode, im, kk, cexp, iexp, ctexp);
        rd(2'd2, c); check("rand_count", c, cexp);
        rd(2'd0, d); check("rand_ctrl", d, ctexp);
`ifndef IRQ_STRETCH_EN
        check("rand_irq", {31'd0, irq}, {31'd0, iexp});
`endif
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
